text_renderer: RTL and testbench

TEXT_RENDERER -- requirements
Module: text_renderer

---
 rtl/text_pkg.sv | 52 +++++
 rtl/phase_divider.sv | 33 +++
 rtl/text_renderer.sv | 116 +++++++++++
 tb/tb_text_renderer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared widths, cursor-style encodings, the character-attribute record and
// the per-pixel shading rule used by the text renderer.
package text_pkg;

    localparam int DEF_COLOR_BITS    = 3;
    localparam int DEF_CHAR_WIDTH    = 8;
    localparam int DEF_BLINK_FRAMES  = 32;
    localparam int DEF_CURSOR_FRAMES = 16;

    localparam int CURSOR_BLOCK     = 0;
    localparam int CURSOR_UNDERLINE = 1;

    typedef struct packed {
        logic [DEF_COLOR_BITS-1:0] fg;
        logic [DEF_COLOR_BITS-1:0] bg;
        logic                      blink;
        logic                      invert;
        logic                      cursor_here;
    } char_attr_t;

    // Ordering matters: blink blanks first, invert flips, the cursor goes on top.
    function automatic logic shade_pixel(
        input logic raw,
        input logic blink,
        input logic blink_phase,
        input logic invert,
        input logic cursor_here,
        input logic cursor_phase,
        input logic last_row,
        input logic underline
    );
        logic p;
        p = raw;
        if (blink && !blink_phase) begin
            p = 1'b0;
        end
        if (invert) begin
            p = ~p;
        end
        if (cursor_here && cursor_phase) begin
            if (underline) begin
                if (last_row) begin
                    p = 1'b1;
                end
            end else begin
                p = ~p;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/phase_divider.sv
// Frame-tick divider: toggles a visibility phase every N ticks, starting visible.
module phase_divider #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic reset_button,
    input  logic tick,
    output logic phase
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] count_reg;
    logic          phase_reg;

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            count_reg <= '0;
            phase_reg <= 1'b1;
        end else if (tick) begin
            if (count_reg == LAST) begin
                count_reg <= '0;
                phase_reg <= ~phase_reg;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/text_renderer.sv
// Character-cell pixel renderer: latches one glyph row plus attributes per
// character and turns the selected column into a registered DAC colour.
module text_renderer
    import text_pkg::*;
#(
    parameter int  COLOR_BITS    = DEF_COLOR_BITS,
    parameter int  CHAR_WIDTH    = DEF_CHAR_WIDTH,
    parameter int  BLINK_FRAMES  = DEF_BLINK_FRAMES,
    parameter int  CURSOR_FRAMES = DEF_CURSOR_FRAMES,
    parameter int  CURSOR_MODE   = CURSOR_BLOCK,
    localparam int XW            = (CHAR_WIDTH > 1) ? $clog2(CHAR_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset_button,
    input  logic                  load_char,
    input  logic [CHAR_WIDTH-1:0] row_pixels,
    input  logic [COLOR_BITS-1:0] foreground,
    input  logic [COLOR_BITS-1:0] background,
    input  logic                  blink,
    input  logic                  invert,
    input  logic                  cursor_here,
    input  logic                  last_row,
    input  logic [XW-1:0]         xchar,
    input  logic                  drawing,
    input  logic                  frame_start,
    output logic [COLOR_BITS-1:0] dac,
    output logic                  blink_phase,
    output logic                  cursor_phase
);

    localparam logic UNDERLINE = (CURSOR_MODE == CURSOR_UNDERLINE);

    logic [CHAR_WIDTH-1:0] row_reg;
    logic [COLOR_BITS-1:0] fg_reg;
    logic [COLOR_BITS-1:0] bg_reg;
    logic                  blink_reg;
    logic                  invert_reg;
    logic                  cursor_reg;
    logic                  last_row_reg;

    logic                  raw_pixel;
    logic                  pixel_next;
    logic [COLOR_BITS-1:0] color_next;
    logic [COLOR_BITS-1:0] dac_reg;

    // The incoming character only becomes active after this edge, so the
    // pixel produced in a load cycle still belongs to the previous character.
    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            row_reg      <= '0;
            fg_reg       <= '0;
            bg_reg       <= '0;
            blink_reg    <= 1'b0;
            invert_reg   <= 1'b0;
            cursor_reg   <= 1'b0;
            last_row_reg <= 1'b0;
        end else if (load_char) begin
            row_reg      <= row_pixels;
            fg_reg       <= foreground;
            bg_reg       <= background;
            blink_reg    <= blink;
            invert_reg   <= invert;
            cursor_reg   <= cursor_here;
            last_row_reg <= last_row;
        end
    end

    phase_divider #(
        .N (BLINK_FRAMES)
    ) u_blink_div (
        .clk          (clk),
        .reset_button (reset_button),
        .tick         (frame_start),
        .phase        (blink_phase)
    );

    phase_divider #(
        .N (CURSOR_FRAMES)
    ) u_cursor_div (
        .clk          (clk),
        .reset_button (reset_button),
        .tick         (frame_start),
        .phase        (cursor_phase)
    );

    // Columns past the glyph width (non power-of-two cells) read as unlit.
    always_comb begin
        raw_pixel = 1'b0;
        if (int'(xchar) < CHAR_WIDTH) begin
            raw_pixel = row_reg[xchar];
        end
    end

    always_comb begin
        pixel_next = shade_pixel(raw_pixel, blink_reg, blink_phase, invert_reg,
                                 cursor_reg, cursor_phase, last_row_reg, UNDERLINE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLOR_BITS; gi++) begin : g_color
            assign color_next[gi] = drawing & (pixel_next ? fg_reg[gi] : bg_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            dac_reg <= '0;
        end else begin
            dac_reg <= color_next;
        end
    end

    assign dac = dac_reg;

endmodule

// File: tb/tb_text_renderer.sv
// Directed and randomized checks of two text_renderer configurations against
// a frame-count based reference model.
module tb_text_renderer;
    import text_pkg::*;

    localparam int A_CW = 8;
    localparam int A_BF = 2;
    localparam int A_CF = 3;
    localparam int B_CW = 6;
    localparam int B_BF = 1;
    localparam int B_CF = 1;

    logic       clk;
    logic       reset_button;
    logic       load_char;
    logic [7:0] row;
    logic [2:0] foreground;
    logic [2:0] background;
    logic       blink;
    logic       invert;
    logic       cursor_here;
    logic       last_row;
    logic [2:0] xchar;
    logic       drawing;
    logic       frame_start;

    logic [2:0] dac_a;
    logic [2:0] dac_b;
    logic       bp_a;
    logic       cp_a;
    logic       bp_b;
    logic       cp_b;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model: the active character and the number of frames since reset.
    logic [7:0] m_row;
    char_attr_t m_attr;
    logic       m_last;
    int         m_frames;

    logic [2:0] glyph_a [8];
    logic [2:0] glyph_b [8];

    text_renderer #(
        .COLOR_BITS    (3),
        .CHAR_WIDTH    (A_CW),
        .BLINK_FRAMES  (A_BF),
        .CURSOR_FRAMES (A_CF),
        .CURSOR_MODE   (CURSOR_BLOCK)
    ) dut_a (
        .clk          (clk),
        .reset_button (reset_button),
        .load_char    (load_char),
        .row_pixels   (row),
        .foreground   (foreground),
        .background   (background),
        .blink        (blink),
        .invert       (invert),
        .cursor_here  (cursor_here),
        .last_row     (last_row),
        .xchar        (xchar),
        .drawing      (drawing),
        .frame_start  (frame_start),
        .dac          (dac_a),
        .blink_phase  (bp_a),
        .cursor_phase (cp_a)
    );

    text_renderer #(
        .COLOR_BITS    (3),
        .CHAR_WIDTH    (B_CW),
        .BLINK_FRAMES  (B_BF),
        .CURSOR_FRAMES (B_CF),
        .CURSOR_MODE   (CURSOR_UNDERLINE)
    ) dut_b (
        .clk          (clk),
        .reset_button (reset_button),
        .load_char    (load_char),
        .row_pixels   (row[5:0]),
        .foreground   (foreground),
        .background   (background),
        .blink        (blink),
        .invert       (invert),
        .cursor_here  (cursor_here),
        .last_row     (last_row),
        .xchar        (xchar),
        .drawing      (drawing),
        .frame_start  (frame_start),
        .dac          (dac_b),
        .blink_phase  (bp_b),
        .cursor_phase (cp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit phase_visible(input int n);
        return ((m_frames / n) % 2) == 0;
    endfunction

    function automatic logic [2:0] model_dac(input int cw, input int bf, input int cf,
                                             input bit underline);
        bit p;
        if (!drawing) return 3'b000;
        p = (int'(xchar) < cw) ? m_row[xchar] : 1'b0;
        if (m_attr.blink && !phase_visible(bf)) p = 1'b0;
        if (m_attr.invert) p = !p;
        if (m_attr.cursor_here && phase_visible(cf)) begin
            if (underline) p = p | m_last;
            else           p = !p;
        end
        return p ? m_attr.fg : m_attr.bg;
    endfunction

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row    = '0;
        m_attr   = '0;
        m_last   = 1'b0;
        m_frames = 0;
    endtask

    // One pixel clock: predict from pre-edge state, clock, update model, compare.
    task automatic cycle(input string tag);
        logic [2:0] ea;
        logic [2:0] eb;
        ea = model_dac(A_CW, A_BF, A_CF, 1'b0);
        eb = model_dac(B_CW, B_BF, B_CF, 1'b1);
        @(posedge clk);
        #1;
        if (load_char) begin
            m_row              = row;
            m_attr.fg          = foreground;
            m_attr.bg          = background;
            m_attr.blink       = blink;
            m_attr.invert      = invert;
            m_attr.cursor_here = cursor_here;
            m_last             = last_row;
        end
        if (frame_start) m_frames++;
        check3({tag, "/dac_a"}, dac_a, ea);
        check3({tag, "/dac_b"}, dac_b, eb);
        check1({tag, "/bp_a"}, bp_a, phase_visible(A_BF));
        check1({tag, "/cp_a"}, cp_a, phase_visible(A_CF));
        check1({tag, "/bp_b"}, bp_b, phase_visible(B_BF));
        check1({tag, "/cp_b"}, cp_b, phase_visible(B_CF));
        $display("[%0t] %s x=%0d ld=%b fs=%b dr=%b dac_a=%b dac_b=%b ph=%b%b%b%b",
                 $time, tag, xchar, load_char, frame_start, drawing,
                 dac_a, dac_b, bp_a, cp_a, bp_b, cp_b);
    endtask

    // Called just after a sample point; pulls reset low between clock edges.
    task automatic async_reset(input string tag);
        #2 reset_button = 1'b0;
        #1;
        check3({tag, "/rst_dac_a"}, dac_a, 3'b000);
        check3({tag, "/rst_dac_b"}, dac_b, 3'b000);
        check1({tag, "/rst_bp_a"}, bp_a, 1'b1);
        check1({tag, "/rst_cp_a"}, cp_a, 1'b1);
        check1({tag, "/rst_bp_b"}, bp_b, 1'b1);
        check1({tag, "/rst_cp_b"}, cp_b, 1'b1);
        $display("[%0t] %s reset dac_a=%b dac_b=%b", $time, tag, dac_a, dac_b);
        model_reset();
        #1 reset_button = 1'b1;
    endtask

    task automatic set_char(input logic [7:0] r, input logic [2:0] fg, input logic [2:0] bg,
                            input logic bl, input logic inv, input logic cur, input logic lr);
        row         = r;
        foreground  = fg;
        background  = bg;
        blink       = bl;
        invert      = inv;
        cursor_here = cur;
        last_row    = lr;
    endtask

    initial begin
        glyph_a = '{3'b110, 3'b001, 3'b110, 3'b001, 3'b001, 3'b110, 3'b001, 3'b110};
        glyph_b = '{3'b110, 3'b001, 3'b110, 3'b001, 3'b001, 3'b110, 3'b001, 3'b001};

        reset_button = 1'b1;
        load_char    = 1'b0;
        frame_start  = 1'b0;
        drawing      = 1'b0;
        xchar        = '0;
        set_char(8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();

        // Power-on reset
        #1 reset_button = 1'b0;
        #1;
        check3("por/dac_a", dac_a, 3'b000);
        check3("por/dac_b", dac_b, 3'b000);
        check1("por/bp_a", bp_a, 1'b1);
        check1("por/cp_b", cp_b, 1'b1);
        #6 reset_button = 1'b1;

        // Glyph sweep
        set_char(8'b1010_0101, 3'b110, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        drawing   = 1'b1;
        load_char = 1'b1;
        cycle("glyph_load");
        load_char = 1'b0;
        for (int x = 0; x < 8; x++) begin
            xchar = 3'(x);
            cycle("glyph");
            check3("glyph_lit_a", dac_a, glyph_a[x]);
            check3("glyph_lit_b", dac_b, glyph_b[x]);
        end

        // Load coincident with pixel: old character still shown
        set_char(8'h00, 3'b010, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        xchar     = 3'd0;
        load_char = 1'b1;
        cycle("same_cycle");
        check3("same_cycle_old", dac_a, 3'b110);
        load_char = 1'b0;
        cycle("after_load");
        check3("after_load_new", dac_a, 3'b100);

        // drawing low blanks regardless of attributes
        set_char(8'hFF, 3'b111, 3'b111, 1'b0, 1'b1, 1'b1, 1'b1);
        load_char = 1'b1;
        cycle("blank_load");
        load_char = 1'b0;
        drawing   = 1'b0;
        for (int x = 0; x < 4; x++) begin
            xchar = 3'(x * 2);
            cycle("blank");
            check3("blank_lit_a", dac_a, 3'b000);
            check3("blank_lit_b", dac_b, 3'b000);
        end
        drawing = 1'b1;

        // Blink over frames 0..4
        async_reset("pre_blink");
        set_char(8'hFF, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        xchar     = 3'd3;
        load_char = 1'b1;
        cycle("blink_load");
        load_char = 1'b0;
        for (int f = 0; f < 5; f++) begin
            cycle("blink");
            check3("blink_lit_a", dac_a, (f == 2 || f == 3) ? 3'b000 : 3'b111);
            frame_start = 1'b1;
            cycle("blink_fs");
            frame_start = 1'b0;
        end

        // Block cursor on config A
        async_reset("pre_cursor");
        set_char(8'h0F, 3'b101, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        load_char = 1'b1;
        cycle("cur0_load");
        load_char = 1'b0;
        for (int x = 0; x < 8; x++) begin
            xchar = 3'(x);
            cycle("cur0");
            check3("cur0_lit_a", dac_a, (x < 4) ? 3'b010 : 3'b101);
        end

        // Underline cursor on config B
        set_char(8'h00, 3'b011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1);
        load_char = 1'b1;
        cycle("cur1_load");
        load_char = 1'b0;
        for (int x = 0; x < 8; x++) begin
            xchar = 3'(x);
            cycle("cur1");
            check3("cur1_lit_b", dac_b, 3'b011);
        end

        // Reset mid-line with foreground showing and phases toggled
        set_char(8'hFF, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        xchar     = 3'd1;
        load_char = 1'b1;
        cycle("mid_load");
        load_char   = 1'b0;
        frame_start = 1'b1;
        cycle("mid_fs");
        frame_start = 1'b0;
        cycle("mid_show");
        check3("mid_fg_a", dac_a, 3'b111);
        async_reset("mid_line");
        cycle("post_rst");
        check3("post_rst_a", dac_a, 3'b000);
        set_char(8'b1010_0101, 3'b110, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        load_char = 1'b1;
        cycle("reglyph_load");
        load_char = 1'b0;
        for (int x = 0; x < 8; x++) begin
            xchar = 3'(x);
            cycle("reglyph");
            check3("reglyph_lit_a", dac_a, glyph_a[x]);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_char(8'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom));
            load_char   = ($urandom_range(0, 3) == 0);
            frame_start = ($urandom_range(0, 5) == 0);
            drawing     = ($urandom_range(0, 4) != 0);
            xchar       = 3'($urandom);
            cycle("rand");
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
